// File: rtl/tsic_sample_sched.sv
`timescale 1ns/1ps
// tsic_sample_sched: sequences A2D conversions and the temperature datapath
// (capture, multiply, add, transmit) for host reads and periodic auto
// samples. It also handles coefficient writes and a sticky conversion
// timeout. Every datapath strobe is a flop loaded from the next state.
//
// Handshake: cmd_rdy is a single-cycle valid with no ready. A host read or
// write that arrives while the sequencer is busy goes into a one-deep
// host_pend slot. A further one arriving while that slot is full is dropped.
// Configure (opcode 10) and clear-timeout (opcode 11) act in any state.
module tsic_sample_sched #(
  parameter int PRESCALE = 256,
  parameter int CONV_TMO = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  input  logic        cmplt,
  output logic        strt,
  output logic        wrtTmp,
  output logic        mult,
  output logic        addr,
  output logic        WE,
  output logic        trmt,
  output logic        busy,
  output logic        tmo_err,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    MUL   = 3'd4,
    ADD   = 3'd5,
    XMIT  = 3'd6,
    WRT   = 3'd7
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = (CONV_TMO > 1) ? $clog2(CONV_TMO + 1) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CONV_TMO - 1);

  state_t        state, state_nx;
  logic [PW-1:0] psc;
  logic [11:0]   ivl, ivl_inc, period;
  logic          auto_en, auto_pend, auto_tick, psc_wrap;
  logic          host_pend, hp_write, hp_addr;
  logic          is_auto, auto_nx, wr_addr, wr_addr_nx;
  logic [TW-1:0] tmo_cnt;
  logic          cmplt_q, tmo_fire;
  logic          host_cmd, cfg_cmd, clr_cmd;
  logic          take_cmd, serve_host_pend, serve_auto;

  // Opcodes 00 and 01 both have bit 15 clear; bit 14 marks a write.
  assign host_cmd  = cmd_rdy && !cmd[15];
  assign cfg_cmd   = cmd_rdy && (cmd[15:14] == 2'b10);
  assign clr_cmd   = cmd_rdy && (cmd[15:14] == 2'b11);
  assign state_dbg = state;

  assign psc_wrap  = (psc == PSC_LAST);
  assign ivl_inc   = ivl + 12'd1;
  assign auto_tick = psc_wrap && auto_en && (period != 12'd0) && (ivl_inc >= period);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and IDLE arbitration: pending host, then a new host
  // command, then a pending auto sample.
  always_comb begin
    state_nx        = state;
    auto_nx         = is_auto;
    wr_addr_nx      = wr_addr;
    take_cmd        = 1'b0;
    serve_host_pend = 1'b0;
    serve_auto      = 1'b0;
    tmo_fire        = 1'b0;
    case (state)
      IDLE: begin
        if (host_pend) begin
          serve_host_pend = 1'b1;
          auto_nx         = 1'b0;
          if (hp_write) begin
            state_nx   = WRT;
            wr_addr_nx = hp_addr;
          end else begin
            state_nx = CONV;
          end
        end else if (host_cmd) begin
          take_cmd = 1'b1;
          auto_nx  = 1'b0;
          if (cmd[14]) begin
            state_nx   = WRT;
            wr_addr_nx = cmd[12];
          end else begin
            state_nx = CONV;
          end
        end else if (auto_pend) begin
          serve_auto = 1'b1;
          auto_nx    = 1'b1;
          state_nx   = CONV;
        end
      end
      CONV:  state_nx = WAIT;
      WAIT: begin
        if (cmplt_q) begin
          state_nx = STORE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_fire = 1'b1;
          state_nx = IDLE;
        end
      end
      STORE: state_nx = MUL;
      MUL:   state_nx = ADD;
      ADD:   state_nx = XMIT;
      XMIT:  state_nx = IDLE;
      WRT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Interval timer: the prescaler drives the interval counter. A tick
  // raises the sticky auto_pend bit. A tick that lands on an already
  // pending request simply merges with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc       <= '0;
      ivl       <= '0;
      period    <= '0;
      auto_en   <= 1'b0;
      auto_pend <= 1'b0;
    end else begin
      psc <= psc_wrap ? '0 : psc + PW'(1);
      if (cfg_cmd) begin
        period    <= cmd[11:0];
        auto_en   <= cmd[13];
        ivl       <= '0;
        auto_pend <= 1'b0;
      end else begin
        if (psc_wrap) ivl <= auto_tick ? 12'd0 : ivl_inc;
        if (auto_tick)       auto_pend <= 1'b1;
        else if (serve_auto) auto_pend <= 1'b0;
      end
    end
  end

  // One-deep host slot. When the slot is served, a host command arriving
  // in that same IDLE cycle takes its place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_pend <= 1'b0;
      hp_write  <= 1'b0;
      hp_addr   <= 1'b0;
    end else if (serve_host_pend) begin
      host_pend <= host_cmd;
      hp_write  <= cmd[14];
      hp_addr   <= cmd[12];
    end else if (host_cmd && !take_cmd && !host_pend) begin
      host_pend <= 1'b1;
      hp_write  <= cmd[14];
      hp_addr   <= cmd[12];
    end
  end

  // Conversion wait: cmplt is registered only while in WAIT, so an early
  // cmplt is ignored. The timeout counter is held at zero outside WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmplt_q <= 1'b0;
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
      is_auto <= 1'b0;
      wr_addr <= 1'b0;
    end else begin
      cmplt_q <= cmplt && (state == WAIT);
      tmo_cnt <= (state == WAIT) ? tmo_cnt + TW'(1) : '0;
      if (tmo_fire)     tmo_err <= 1'b1;
      else if (clr_cmd) tmo_err <= 1'b0;
      is_auto <= auto_nx;
      wr_addr <= wr_addr_nx;
    end
  end

  // Registered strobes decoded from the next state. An auto sample only
  // transmits if auto_en is still set when XMIT is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strt   <= 1'b0;
      wrtTmp <= 1'b0;
      mult   <= 1'b0;
      addr   <= 1'b0;
      WE     <= 1'b0;
      trmt   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      strt   <= (state_nx == CONV);
      wrtTmp <= (state_nx == STORE);
      mult   <= (state_nx == MUL);
      addr   <= (state_nx == ADD) || ((state_nx == WRT) && wr_addr_nx);
      WE     <= (state_nx == WRT);
      trmt   <= (state_nx == XMIT) && (!auto_nx || auto_en);
      busy   <= (state_nx != IDLE);
    end
  end

endmodule
